// File: rtl/pixel_mem_ctrl.sv
// Sequencer for the 32x32x3 pixel memory: planar load from an input stream,
// and raster-order 3x3 zero-padded window fetch toward the conv datapath.
module pixel_mem_ctrl #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned IMG_DIM = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_start,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                load_done,
  input  logic                fetch_start,
  output logic [3*DATA_W-1:0] pix_out,
  output logic                pix_valid,
  input  logic                pix_ready,
  output logic [3:0]          pix_k,
  output logic [4:0]          pix_row,
  output logic [4:0]          pix_col,
  output logic                pix_last,
  output logic                fetch_done,
  output logic                busy,
  output logic [15:0]         write_pixel_addr,
  output logic [DATA_W-1:0]   write_pixel_data,
  output logic                write_pixel_signal,
  output logic [15:0]         read_pixel_addr,
  output logic                read_pixel_signal,
  input  logic [3*DATA_W-1:0] read_pixel_data
);

  localparam logic [4:0] LastIdx = 5'(IMG_DIM - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StFetch} state_e;

  state_e              state_q, state_d;
  logic [1:0]          ch_q, ch_d, kr_q, kr_d, kc_q, kc_d;
  logic [4:0]          row_q, row_d, col_q, col_d;
  logic                last_q, last_d;  // final word accepted / final beat issued
  logic                wr_sig_q, wr_sig_d;
  logic [15:0]         wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                load_done_q, load_done_d;
  logic                fetch_done_q, fetch_done_d;
  logic [3*DATA_W-1:0] pix_out_q, pix_out_d;
  logic                pix_valid_q, pix_valid_d;
  logic [3:0]          pix_k_q, pix_k_d;
  logic [4:0]          pix_row_q, pix_row_d, pix_col_q, pix_col_d;
  logic                pix_last_q, pix_last_d;

  logic signed [5:0]   nb_row, nb_col;
  logic                nb_in, pix_load, fetch_final;

  // Bounds are checked on the signed 6-bit sum before truncation, so the
  // +1 overflow at row/col 31 lands on a negative value and is padded.
  always_comb begin
    nb_row = $signed({1'b0, row_q}) + $signed({4'b0, kr_q}) - 6'sd1;
    nb_col = $signed({1'b0, col_q}) + $signed({4'b0, kc_q}) - 6'sd1;
    nb_in  = !nb_row[5] && (nb_row[4:0] <= LastIdx) && !nb_col[5] && (nb_col[4:0] <= LastIdx);
  end

  assign busy               = (state_q != StIdle);
  assign in_ready           = (state_q == StLoad) && !last_q;
  assign read_pixel_signal  = (state_q == StFetch) && !last_q && nb_in;
  assign read_pixel_addr    = read_pixel_signal ? {6'b0, nb_row[4:0], nb_col[4:0]} : 16'b0;
  assign pix_load           = (state_q == StFetch) && !last_q && (!pix_valid_q || pix_ready);
  assign fetch_final        = (row_q == LastIdx) && (col_q == LastIdx) &&
                              (kr_q == 2'd2) && (kc_q == 2'd2);

  assign load_done          = load_done_q;
  assign fetch_done         = fetch_done_q;
  assign write_pixel_signal = wr_sig_q;
  assign write_pixel_addr   = wr_addr_q;
  assign write_pixel_data   = wr_data_q;
  assign pix_out            = pix_out_q;
  assign pix_valid          = pix_valid_q;
  assign pix_k              = pix_k_q;
  assign pix_row            = pix_row_q;
  assign pix_col            = pix_col_q;
  assign pix_last           = pix_last_q;

  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    row_d        = row_q;
    col_d        = col_q;
    kr_d         = kr_q;
    kc_d         = kc_q;
    last_d       = last_q;
    wr_sig_d     = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    load_done_d  = 1'b0;
    fetch_done_d = 1'b0;
    pix_out_d    = pix_out_q;
    pix_valid_d  = pix_valid_q;
    pix_k_d      = pix_k_q;
    pix_row_d    = pix_row_q;
    pix_col_d    = pix_col_q;
    pix_last_d   = pix_last_q;

    unique case (state_q)
      StIdle: begin
        if (load_start || fetch_start) begin
          state_d = load_start ? StLoad : StFetch;
          ch_d    = 2'd0;
          row_d   = 5'd0;
          col_d   = 5'd0;
          kr_d    = 2'd0;
          kc_d    = 2'd0;
          last_d  = 1'b0;
        end
      end
      StLoad: begin
        if (last_q) begin
          state_d = StIdle;
          last_d  = 1'b0;
        end else if (in_valid) begin
          wr_sig_d  = 1'b1;
          wr_addr_d = {4'b0, ch_q, row_q, col_q};
          wr_data_d = in_data;
          col_d     = col_q + 5'd1;
          if (col_q == LastIdx) begin
            col_d = 5'd0;
            row_d = row_q + 5'd1;
            if (row_q == LastIdx) begin
              row_d = 5'd0;
              ch_d  = ch_q + 2'd1;
              if (ch_q == 2'd2) begin
                ch_d        = 2'd0;
                last_d      = 1'b1;
                load_done_d = 1'b1;
              end
            end
          end
        end
      end
      StFetch: begin
        if (pix_valid_q && pix_ready && pix_last_q) begin
          pix_valid_d  = 1'b0;
          fetch_done_d = 1'b1;
          state_d      = StIdle;
          last_d       = 1'b0;
        end else if (pix_load) begin
          pix_valid_d = 1'b1;
          pix_out_d   = read_pixel_signal ? read_pixel_data : '0;
          pix_k_d     = ({2'b0, kr_q} << 1) + {2'b0, kr_q} + {2'b0, kc_q};
          pix_row_d   = row_q;
          pix_col_d   = col_q;
          pix_last_d  = fetch_final;
          kc_d        = kc_q + 2'd1;
          if (kc_q == 2'd2) begin
            kc_d = 2'd0;
            kr_d = kr_q + 2'd1;
            if (kr_q == 2'd2) begin
              kr_d  = 2'd0;
              col_d = col_q + 5'd1;
              if (col_q == LastIdx) begin
                col_d = 5'd0;
                row_d = row_q + 5'd1;
                if (row_q == LastIdx) begin
                  row_d  = 5'd0;
                  last_d = 1'b1;
                end
              end
            end
          end
        end else if (pix_ready) begin
          pix_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      ch_q         <= 2'd0;
      row_q        <= 5'd0;
      col_q        <= 5'd0;
      kr_q         <= 2'd0;
      kc_q         <= 2'd0;
      last_q       <= 1'b0;
      wr_sig_q     <= 1'b0;
      wr_addr_q    <= 16'd0;
      wr_data_q    <= '0;
      load_done_q  <= 1'b0;
      fetch_done_q <= 1'b0;
      pix_out_q    <= '0;
      pix_valid_q  <= 1'b0;
      pix_k_q      <= 4'd0;
      pix_row_q    <= 5'd0;
      pix_col_q    <= 5'd0;
      pix_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      row_q        <= row_d;
      col_q        <= col_d;
      kr_q         <= kr_d;
      kc_q         <= kc_d;
      last_q       <= last_d;
      wr_sig_q     <= wr_sig_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      load_done_q  <= load_done_d;
      fetch_done_q <= fetch_done_d;
      pix_out_q    <= pix_out_d;
      pix_valid_q  <= pix_valid_d;
      pix_k_q      <= pix_k_d;
      pix_row_q    <= pix_row_d;
      pix_col_q    <= pix_col_d;
      pix_last_q   <= pix_last_d;
    end
  end

endmodule

// File: tb/tb_pixel_mem_ctrl.sv
// Scoreboard bench for pixel_mem_ctrl: a behavioural memory, a reference image
// and queues of expected writes/beats checked by an independent monitor.
module tb_pixel_mem_ctrl;

  localparam int DIM = 32;
  localparam int NW  = 3 * DIM * DIM;
  localparam int NB  = 9 * DIM * DIM;

  logic        clk = 1'b0;
  logic        rst, load_start, in_valid, in_ready, load_done, fetch_start;
  logic [15:0] in_data;
  logic [47:0] pix_out, read_pixel_data;
  logic        pix_valid, pix_ready, pix_last, fetch_done, busy;
  logic [3:0]  pix_k;
  logic [4:0]  pix_row, pix_col;
  logic [15:0] write_pixel_addr, write_pixel_data, read_pixel_addr;
  logic        write_pixel_signal, read_pixel_signal;

  always #5 clk = ~clk;

  pixel_mem_ctrl #(.DATA_W(16), .IMG_DIM(DIM)) dut (
    .clk(clk), .rst(rst), .load_start(load_start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .load_done(load_done),
    .fetch_start(fetch_start), .pix_out(pix_out), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .pix_k(pix_k), .pix_row(pix_row), .pix_col(pix_col),
    .pix_last(pix_last), .fetch_done(fetch_done), .busy(busy),
    .write_pixel_addr(write_pixel_addr), .write_pixel_data(write_pixel_data),
    .write_pixel_signal(write_pixel_signal), .read_pixel_addr(read_pixel_addr),
    .read_pixel_signal(read_pixel_signal), .read_pixel_data(read_pixel_data)
  );

  typedef struct packed {
    logic [47:0] d;
    logic [3:0]  k;
    logic [4:0]  r;
    logic [4:0]  c;
    logic        last;
  } beat_t;

  int          n_checks = 0;
  int          n_fail = 0;
  beat_t       bq[$];
  logic [31:0] wq[$];
  logic [15:0] ref_img [3][DIM][DIM];
  logic [47:0] mem [1024];
  int          beats_seen, last_seen, done_seen;
  logic [15:0] seen_443;
  bit          chk_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not as required", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory behaves as a plain array; unread cycles return garbage so that a
  // padded beat which wrongly samples the bus is visible.
  assign read_pixel_data = read_pixel_signal ? mem[read_pixel_addr[9:0]] : 48'hBAD0_BAD0_BAD0;

  always @(posedge clk) begin
    if (write_pixel_signal && write_pixel_addr[11:10] != 2'd3)
      mem[write_pixel_addr[9:0]][int'(write_pixel_addr[11:10]) * 16 +: 16] <= write_pixel_data;
  end

  // Monitor
  beat_t       cur, prev, e;
  logic [15:0] prev_ra;
  bit          stall_prev = 0;
  bit          exp_done = 0;

  always @(negedge clk) begin
    cur = '{d: pix_out, k: pix_k, r: pix_row, c: pix_col, last: pix_last};
    if (write_pixel_signal) begin
      if (wq.size() == 0) fail("unexpected_write");
      else check("write", {write_pixel_addr, write_pixel_data}, wq.pop_front());
      if (write_pixel_addr == 16'h0443) seen_443 = write_pixel_data;
    end
    if (in_ready) check("no_read_in_load", read_pixel_signal, 0);
    if (pix_valid) check("no_write_in_fetch", write_pixel_signal, 0);
    if (stall_prev && !rst) begin
      check("hold_beat", cur, prev);
      check("hold_raddr", read_pixel_addr, prev_ra);
    end
    if (exp_done) check("fetch_done_pulse", {fetch_done, busy}, 2'b10);
    else if (fetch_done) fail("spurious_fetch_done");
    if (fetch_done) done_seen++;
    if (pix_valid && pix_ready) begin
      if (bq.size() == 0) fail("unexpected_beat");
      else begin
        e = bq.pop_front();
        check("beat", cur, e);
      end
      if (chk_b && pix_row == 5'd5 && pix_col == 5'd7 && pix_k == 4'd0)
        check("beat_5_7_0", pix_out, {16'd1, 16'd6, 16'd4});
      if (chk_b && pix_row == 5'd0 && pix_col == 5'd0 && pix_k <= 4'd4)
        check("beat_0_0_k", pix_out, (pix_k == 4'd4) ? {16'd1, 16'd0, 16'd0} : 48'd0);
      beats_seen++;
      if (pix_last) last_seen++;
    end
    exp_done   = pix_valid && pix_ready && pix_last && !rst;
    stall_prev = pix_valid && !pix_ready && !rst;
    prev       = cur;
    prev_ra    = read_pixel_addr;
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {in_ready, load_done, pix_valid, pix_last, fetch_done, busy,
          write_pixel_signal, read_pixel_signal, write_pixel_addr, write_pixel_data,
          read_pixel_addr}, 64'd0);
    check({tag, "_pix"}, {pix_out, pix_k, pix_row, pix_col}, 64'd0);
  endtask

  function automatic logic [15:0] word_for(input int dmode, input int ch, input int r,
                                           input int c, input int idx);
    if (dmode == 0) return 16'(idx);
    if (dmode == 1) return (ch == 0) ? 16'(r) : (ch == 1) ? 16'(c) : 16'd1;
    return 16'($urandom);
  endfunction

  // vmode: 0 continuous valid, 1 valid every other cycle, 2 random valid
  task automatic do_load(input int vmode, input int dmode, input bit dual);
    int i = 0, cyc, ch, r, c;
    bit v, fs_sent = 0;
    logic [15:0] w;
    load_start  = 1'b1;
    fetch_start = dual;
    tick();
    load_start  = 1'b0;
    fetch_start = 1'b0;
    cyc = 1;
    check("load_enter", {busy, in_ready, pix_valid}, 3'b110);
    while (i < NW && cyc < 20000) begin
      ch = i / (DIM * DIM);
      r  = (i / DIM) % DIM;
      c  = i % DIM;
      v  = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 1) : 1'($urandom_range(0, 1));
      w  = word_for(dmode, ch, r, c, i);
      in_valid = v;
      in_data  = v ? w : 16'($urandom);
      if (dual && i == 1000 && !fs_sent) begin
        fetch_start = 1'b1;
        fs_sent     = 1;
      end
      if (v && in_ready) begin
        ref_img[ch][r][c] = w;
        wq.push_back({4'b0, 2'(ch), 5'(r), 5'(c), w});
        i++;
      end
      tick();
      cyc++;
      fetch_start = 1'b0;
    end
    in_valid = 1'b0;
    if (i < NW) begin
      fail("load_timeout");
      return;
    end
    check("load_done_cycle", {load_done, write_pixel_signal, in_ready, busy}, 4'b1101);
    if (vmode == 0) check("load_latency", cyc, 3073);
    if (vmode == 1) check("load_latency_toggle", cyc, 6144);
    tick();
    check("load_idle", {load_done, in_ready, busy, write_pixel_signal, pix_valid}, 5'b0);
    check("load_writes_left", wq.size(), 0);
  endtask

  task automatic push_beats();
    beat_t b;
    int nr, nc;
    bq.delete();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            nr = r + dr;
            nc = c + dc;
            if (nr >= 0 && nr < DIM && nc >= 0 && nc < DIM)
              b.d = {ref_img[2][nr][nc], ref_img[1][nr][nc], ref_img[0][nr][nc]};
            else
              b.d = 48'd0;
            b.k    = 4'(3 * (dr + 1) + (dc + 1));
            b.r    = 5'(r);
            b.c    = 5'(c);
            b.last = (r == DIM - 1) && (c == DIM - 1) && (dr == 1) && (dc == 1);
            bq.push_back(b);
          end
  endtask

  // rmode: 0 ready high except a 5-cycle gap, 1 random ready
  task automatic do_fetch(input int rmode, input int abort_at);
    int cyc;
    push_beats();
    beats_seen  = 0;
    last_seen   = 0;
    done_seen   = 0;
    pix_ready   = 1'b1;
    fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("fetch_enter", {busy, pix_valid, read_pixel_signal, in_ready}, 4'b1000);
    cyc = 1;
    while (done_seen == 0 && cyc < 40000) begin
      pix_ready = (rmode == 0) ? !(cyc >= 300 && cyc < 305) : ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
      if (cyc == 2)
        check("first_beat", {pix_valid, pix_out, pix_k, pix_row, pix_col}, {1'b1, 62'd0});
      if (abort_at >= 0 && beats_seen >= abort_at) begin
        rst = 1'b1;
        tick();
        check_all_zero("abort");
        rst = 1'b0;
        repeat (20) tick();
        check("abort_no_done", {done_seen[7:0], busy}, 9'd0);
        return;
      end
    end
    pix_ready = 1'b0;
    if (done_seen == 0) fail("fetch_timeout");
    check("beat_count", beats_seen, NB);
    check("last_count", last_seen, 1);
    check("beats_left", bq.size(), 0);
    tick();
    check("fetch_idle", {busy, pix_valid, fetch_done}, 3'b0);
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; fetch_start = 1'b0;
    in_valid = 1'b0; in_data = 16'd0; pix_ready = 1'b0;
    chk_b = 0;
    seen_443 = 16'hFFFF;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    do_load(0, 0, 1);
    check("write_0x443", seen_443, 16'd1091);
    do_load(1, 1, 0);
    chk_b = 1;
    do_fetch(0, -1);
    do_fetch(0, 100);
    do_fetch(1, -1);
    chk_b = 0;
    do_load(2, 2, 0);
    do_fetch(1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pixel_mem_ctrl.md
# pixel_mem_ctrl

Sequencer for the 32x32x3 local pixel memory. It runs in two exclusive modes. Load mode streams 16-bit channel words from the input bus into the memory's write port in planar order. Fetch mode walks the stored image in raster order and, for every pixel centre, emits its 3x3 neighbourhood as nine 48-bit RGB beats to the convolution datapath, with zero padding at the borders. It sits between the layer's DMA/input stream and the conv PE array and owns both memory ports.

## Interface
- DATA_W, 16, width of one channel word
- IMG_DIM, 32, image height = width; power of two, at most 32; row/col fields are 5 bits
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- load_start  in  1  pulse; begins a load when idle
- in_data  in  16  channel word
- in_valid / in_ready  in / out  1  input handshake; a word transfers when both are high
- load_done  out  1  one-cycle pulse after the last write is issued
- fetch_start  in  1  pulse; begins a window fetch when idle
- pix_out  out  48  {B,G,R} of the current window element
- pix_valid / pix_ready  out / in  1  output handshake
- pix_k  out  4  window index 0..8, where k = 3*(dr+1) + (dc+1)
- pix_row, pix_col  out  5  centre coordinate
- pix_last  out  1  high with the final beat (31,31,k=8)
- fetch_done  out  1  one-cycle pulse after the final beat transfers
- busy  out  1  high whenever the block is not IDLE
- write_pixel_addr  out  16  {4'b0, ch[1:0], row[4:0], col[4:0]}
- write_pixel_data  out  16  word being written
- write_pixel_signal  out  1  memory write strobe
- read_pixel_addr  out  16  {6'b0, row, col}
- read_pixel_signal  out  1  memory read enable
- read_pixel_data  in  48  combinational read data from the memory, {B,G,R}

## Operation
- States: IDLE, LOAD, FETCH.
- IDLE -> LOAD on load_start. IDLE -> FETCH on fetch_start. If both are asserted in the same cycle, LOAD wins.
- Starts are ignored outside IDLE.
- LOAD
  - in_ready is 1.
  - Counters run ch 0..2 (outer), then row 0..31, then col 0..31 (inner). They advance only on an accepted word.
  - Each accepted word registers write_pixel_signal=1 with its address and data for exactly one cycle.
  - After the 3072nd word is accepted: in_ready drops, the next cycle carries the final write plus load_done, and the state returns to IDLE.
- FETCH
  - Counters run row, then col, then k (k is innermost). Neighbour = (row+dr, col+dc) with dr, dc in {-1, 0, +1}.
  - Neighbour in bounds: drive read_pixel_addr and read_pixel_signal=1, and capture read_pixel_data into pix_out.
  - Neighbour out of bounds (coordinate < 0 or > IMG_DIM-1): read_pixel_signal=0 and pix_out=48'd0.
  - One-entry output register. The counters advance and a new beat loads when (!pix_valid || pix_ready).
  - Total of 9216 beats. After the last beat transfers: fetch_done pulses and the state returns to IDLE.
- Coordinate arithmetic uses 6-bit signed values; bounds are checked before truncating to 5 bits. There is no wrap-around.
- The block never writes the memory in FETCH and never reads it in LOAD.

## Timing
- Reset values: every output is 0 (in_ready=0, busy=0, pix_valid=0, all address/data outputs 0). The state goes to IDLE and all counters clear.
- Memory contents are not touched by reset.
- rst asserted mid-operation aborts on the next edge. No done pulse is issued and partial data stays in memory.
- Start pulse at cycle t: busy=1 and the state is LOAD/FETCH at t+1.
- LOAD: in_ready=1 from t+1. A word accepted at cycle n appears on the write port at n+1.
- FETCH: the first address (0,0,k=0) is presented at t+1, which is out of bounds, so padded. First pix_valid at t+2.
- FETCH throughput is one beat per cycle under continuous pix_ready.
- Backpressure: while pix_valid=1 and pix_ready=0, pix_out, pix_k, pix_row, pix_col, pix_last and the read address all hold stable.
- fetch_done is asserted in the cycle after the pix_last beat transfers. busy=0 in that same cycle.
- load_done coincides with the final write_pixel_signal cycle. busy=0 in the following cycle.

## Test plan
- Load with continuous valid, in_data = index 0..3071 -> write at ch=1,row=2,col=3 carries addr 0x0443 and data 1091. load_done occurs exactly 3073 cycles after load_start. in_ready is 0 afterwards.
- Load with in_valid toggling every other cycle -> 3072 writes in order with no duplicate or skipped address. load_done is delayed accordingly.
- Fetch after loading R=row, G=col, B=1 at every pixel -> beat (row 5, col 7, k=0) gives pix_out {16'd1, 16'd6, 16'd4}. Beat (0,0,k=0..3) gives 0 for k=0,1,2,3 and {1,0,0} for k=4.
- Fetch with pix_ready low for 5 cycles mid-stream -> outputs are held. Total beats = 9216. pix_last is seen once at (31,31,8). fetch_done follows in the next cycle.
- load_start and fetch_start asserted together -> LOAD is entered and the fetch_start is ignored. fetch_start issued during LOAD is ignored.
- rst asserted during FETCH at beat 100 -> next cycle all outputs are 0, busy=0, and no fetch_done pulse. A subsequent fetch_start restarts at (0,0,k=0).
